// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: byte/half/word loads and stores,
// read-modify-write for sub-word stores, misalignment detection.
module load_store_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q;
  logic        ready_q, resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic [31:0] addr_q, mem_wdata_q, resp_rdata_q;
  logic [15:0] wdata_q;
  logic [1:0]  size_q, cnt_q;
  logic        unsigned_q, write_q;

  logic        accept, misaligned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data, merged;

  assign accept = req_valid_i && ready_q;

  always_comb begin
    misaligned = (req_size_i == 2'b11)
              || (req_size_i == 2'b01 && req_addr_i[0])
              || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
  end

  // Extraction and merge both work on the word currently returned by memory.
  always_comb begin
    byte_lane = 8'(mem_rdata_i >> {addr_q[1:0], 3'b000});
    half_lane = 16'(mem_rdata_i >> {addr_q[1], 4'b0000});
    load_data = mem_rdata_i;
    merged    = mem_rdata_i;
    case (size_q)
      2'b00: begin
        load_data = unsigned_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_data = unsigned_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      unsigned_q   <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q     <= 1'b0;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i[15:0];
            size_q      <= req_size_i;
            unsigned_q  <= req_unsigned_i;
            write_q     <= req_write_i;
            mem_wdata_q <= req_wdata_i;
            cnt_q       <= 2'(RD_LAT - 1);
            if (misaligned) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_write_i && req_size_i == 2'b10) begin
              state_q     <= WR;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= RD;
              mem_read_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        RD: begin
          if (cnt_q == 2'd0) begin
            mem_read_q <= 1'b0;
            if (write_q) begin
              state_q     <= WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= merged;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= load_data;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WR: begin
          mem_write_q  <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_write_o  = mem_write_q;
  assign mem_read_o   = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
// (RD_LAT=1 and RD_LAT=3 instances).
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid1, valid3;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        ready1, resp_valid1, resp_err1, mem_write1, mem_read1;
  logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        ready3, resp_valid3, resp_err3, mem_write3, mem_read3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  load_store_unit #(.RD_LAT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid1), .req_ready_o(ready1),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(resp_valid1),
    .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_write_o(mem_write1), .mem_read_o(mem_read1),
    .mem_rdata_i(mem_rdata1));

  load_store_unit #(.RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid3), .req_ready_o(ready3),
    .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(resp_valid3),
    .resp_rdata_o(resp_rdata3), .resp_err_o(resp_err3), .mem_addr_o(mem_addr3),
    .mem_wdata_o(mem_wdata3), .mem_write_o(mem_write3), .mem_read_o(mem_read3),
    .mem_rdata_i(mem_rdata3));

  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  int          wr_cnt1 = 0, rd_cnt1 = 0, both_hi = 0;
  logic [31:0] last_wd1 = '0, last_wa1 = '0;

  assign mem_rdata1 = mem1[mem_addr1[5:2]];
  assign mem_rdata3 = mem3[mem_addr3[5:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= '0;
        mem3[i] <= '0;
      end
    end else begin
      if (mem_write1) begin
        mem1[mem_addr1[5:2]] <= mem_wdata1;
        last_wd1 <= mem_wdata1;
        last_wa1 <= mem_addr1;
        wr_cnt1  <= wr_cnt1 + 1;
      end
      if (mem_read1) rd_cnt1 <= rd_cnt1 + 1;
      if (mem_write3) mem3[mem_addr3[5:2]] <= mem_wdata3;
    end
    if ((mem_write1 && mem_read1) || (mem_write3 && mem_read3)) both_hi <= both_hi + 1;
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit s3, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input string tag);
    exp_t e;
    exp_t got;
    int   n;
    logic rv;
    n = 0;
    while (!(s3 ? ready3 : ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(s3 ? ready3 : ready1), 32'd1);
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    req_write = wr; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    if (s3) valid3 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    n = 0;
    rv = 1'b0;
    while (!rv && n < 20) begin
      @(negedge clk);
      n++;
      rv = s3 ? resp_valid3 : resp_valid1;
    end
    got = sb.pop_front();
    check({tag, "_resp_seen"}, 32'(rv), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(got.lat));
    check({tag, "_rdata"}, s3 ? resp_rdata3 : resp_rdata1, got.rd);
    check({tag, "_err"}, 32'(s3 ? resp_err3 : resp_err1), 32'(got.err));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(s3 ? resp_valid3 : resp_valid1), 32'd0);
  endtask

  int   wc0, rc0, n;
  logic seen;

  initial begin
    valid1 = 1'b1; valid3 = 1'b0;
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h1234_5678;

    // reset with a request pending
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready1), 32'd0);
    check("rst_memw", 32'(mem_write1), 32'd0);
    check("rst_memr", 32'(mem_read1), 32'd0);
    check("rst_resp", 32'(resp_valid1), 32'd0);
    check("rst_addr", mem_addr1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready1), 32'd1);
    check("post_rst_noacc", 32'(wr_cnt1 + rd_cnt1), 32'd0);
    valid1 = 1'b0;
    @(negedge clk);

    // word store / load
    wc0 = wr_cnt1;
    issue(0, 1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, 2, "sw8");
    check("sw8_wcount", 32'(wr_cnt1 - wc0), 32'd1);
    check("sw8_waddr", last_wa1, 32'h8);
    check("sw8_wdata", last_wd1, 32'hDEAD_BEEF);
    issue(0, 0, 2'b10, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, 2, "lw8");

    // byte read-modify-write and extraction
    issue(0, 1, 2'b10, 0, 32'h8, 32'h1122_3344, 32'h0, 0, 2, "sw8b");
    issue(0, 1, 2'b00, 0, 32'h9, 32'hFFFF_FF7F, 32'h0, 0, 3, "sb9");
    check("sb9_wdata", last_wd1, 32'h1122_7F44);
    issue(0, 0, 2'b00, 0, 32'hB, 32'h0, 32'h0000_0011, 0, 2, "lbB");
    issue(0, 1, 2'b00, 0, 32'hA, 32'h0000_0080, 32'h0, 0, 3, "sbA");
    check("sbA_wdata", last_wd1, 32'h1180_7F44);
    issue(0, 0, 2'b00, 0, 32'hA, 32'h0, 32'hFFFF_FF80, 0, 2, "lbA");
    issue(0, 0, 2'b00, 1, 32'hA, 32'h0, 32'h0000_0080, 0, 2, "lbuA");

    // halfword
    issue(0, 1, 2'b01, 0, 32'h6, 32'h0000_A5A5, 32'h0, 0, 3, "sh6");
    check("sh6_wdata", last_wd1, 32'hA5A5_0000);
    check("sh6_waddr", last_wa1, 32'h4);
    issue(0, 0, 2'b01, 1, 32'h6, 32'h0, 32'h0000_A5A5, 0, 2, "lhu6");
    issue(0, 0, 2'b01, 0, 32'h6, 32'h0, 32'hFFFF_A5A5, 0, 2, "lh6");
    issue(0, 0, 2'b10, 0, 32'h4, 32'h0, 32'hA5A5_0000, 0, 2, "lw4");

    // misaligned / illegal: no memory traffic
    wc0 = wr_cnt1; rc0 = rd_cnt1;
    issue(0, 0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 1, 1, "err_lw2");
    issue(0, 0, 2'b01, 0, 32'h1, 32'h0, 32'h0, 1, 1, "err_lh1");
    issue(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1, "err_sz3");
    issue(0, 1, 2'b10, 0, 32'h3, 32'h55, 32'h0, 1, 1, "err_sw3");
    check("err_no_wr", 32'(wr_cnt1 - wc0), 32'd0);
    check("err_no_rd", 32'(rd_cnt1 - rc0), 32'd0);

    // reset during the WR phase of a halfword store
    req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h1234;
    valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_write1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rmw_reached_wr", 32'(mem_write1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_drop", 32'(mem_write1), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | resp_valid1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      seen = seen | resp_valid1;
    end
    check("rst_no_resp", 32'(seen), 32'd0);

    // RD_LAT=3 instance
    issue(1, 1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, 2, "l3_sw8");
    issue(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 0, 4, "l3_lw8");
    issue(1, 1, 2'b00, 0, 32'hB, 32'h0000_00C3, 32'h0, 0, 5, "l3_sbB");
    issue(1, 0, 2'b10, 0, 32'h8, 32'h0, 32'hC3AD_BEEF, 0, 4, "l3_lw8b");

    check("rd_wr_exclusive", 32'(both_hi), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
